// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - action codes, account record and reset table for the atm engine
package atm_pkg;

    localparam int DEFAULT_NUM_ACCOUNTS = 4;

    localparam logic [2:0] ACT_IDLE       = 3'b000;
    localparam logic [2:0] ACT_INQUIRY    = 3'b011;
    localparam logic [2:0] ACT_WITHDRAW   = 3'b100;
    localparam logic [2:0] ACT_DEPOSIT    = 3'b101;
    localparam logic [2:0] ACT_TRANSFER   = 3'b110;
    localparam logic [2:0] ACT_PIN_CHANGE = 3'b111;

    typedef struct packed {
        logic [11:0] number;
        logic [3:0]  pin;
        logic [15:0] balance;
    } account_t;

    // Reset contents of the account table; entries past the fixed four load as zero.
    function automatic account_t reset_entry(input int idx);
        account_t e;
        case (idx)
            0:       e = '{number: 12'h0A1, pin: 4'd1, balance: 16'd1000};
            1:       e = '{number: 12'h0B2, pin: 4'd2, balance: 16'd500};
            2:       e = '{number: 12'h0C3, pin: 4'd3, balance: 16'd2000};
            3:       e = '{number: 12'h0D4, pin: 4'd4, balance: 16'd0};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/atm_account_table.sv
// rtl/atm_account_table.sv - account register array with source/destination lookup and two write ports
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset (reloads reset table)
//   src_number_i / dst_number_i  account numbers to look up
//   src_hit_o, src_idx_o, src_pin_o, src_balance_o   source lookup result
//   dst_hit_o, dst_idx_o, dst_balance_o              destination lookup result
//   wa_*                         write port A: pin and balance of one entry
//   wb_*                         write port B: balance of one entry (transfer destination)
module atm_account_table
    import atm_pkg::*;
#(
    parameter int N  = DEFAULT_NUM_ACCOUNTS,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [11:0]   src_number_i,
    input  logic [11:0]   dst_number_i,
    output logic          src_hit_o,
    output logic [IW-1:0] src_idx_o,
    output logic [3:0]    src_pin_o,
    output logic [15:0]   src_balance_o,
    output logic          dst_hit_o,
    output logic [IW-1:0] dst_idx_o,
    output logic [15:0]   dst_balance_o,
    input  logic          wa_en_i,
    input  logic [IW-1:0] wa_idx_i,
    input  logic [3:0]    wa_pin_i,
    input  logic [15:0]   wa_balance_i,
    input  logic          wb_en_i,
    input  logic [IW-1:0] wb_idx_i,
    input  logic [15:0]   wb_balance_i
);

    account_t table_q [N];

    // First matching entry wins, so a duplicated number resolves to the lowest index.
    always_comb begin
        src_hit_o     = 1'b0;
        src_idx_o     = '0;
        src_pin_o     = '0;
        src_balance_o = '0;
        dst_hit_o     = 1'b0;
        dst_idx_o     = '0;
        dst_balance_o = '0;
        for (int i = 0; i < N; i++) begin
            if (!src_hit_o && table_q[i].number == src_number_i) begin
                src_hit_o     = 1'b1;
                src_idx_o     = IW'(i);
                src_pin_o     = table_q[i].pin;
                src_balance_o = table_q[i].balance;
            end
            if (!dst_hit_o && table_q[i].number == dst_number_i) begin
                dst_hit_o     = 1'b1;
                dst_idx_o     = IW'(i);
                dst_balance_o = table_q[i].balance;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N; i++) begin
            if (rst_i) begin
                table_q[i] <= reset_entry(i);
            end else begin
                if (wa_en_i && wa_idx_i == IW'(i)) begin
                    table_q[i].pin     <= wa_pin_i;
                    table_q[i].balance <= wa_balance_i;
                end
                if (wb_en_i && wb_idx_i == IW'(i)) begin
                    table_q[i].balance <= wb_balance_i;
                end
            end
        end
    end

endmodule

// File: rtl/atm.sv
// rtl/atm.sv - ATM transaction engine: command accept, authentication, operation decode, result registers
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   accNumber, pin           requesting account and presented PIN
//   action                   command code (011 inquiry, 100 withdraw, 101 deposit, 110 transfer, 111 PIN change)
//   amount, destinationAcc   operand and transfer destination
//   pinChange, newPin        PIN-change enable and replacement PIN
//   balance, transactionSuccess, pinSuccess   results of the last accepted command
module atm
    import atm_pkg::*;
#(
    parameter int NUM_ACCOUNTS = DEFAULT_NUM_ACCOUNTS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] accNumber,
    input  logic [3:0]  pin,
    input  logic [2:0]  action,
    input  logic [15:0] amount,
    input  logic        pinChange,
    input  logic [3:0]  newPin,
    input  logic [11:0] destinationAcc,
    output logic [15:0] balance,
    output logic        transactionSuccess,
    output logic        pinSuccess
);

    localparam int IW = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;

    logic [2:0]    prev_action_q;
    logic [15:0]   balance_q, balance_d;
    logic          success_q, success_d;
    logic          pin_ok_q, pin_ok_d;

    logic          src_hit, dst_hit;
    logic [IW-1:0] src_idx, dst_idx;
    logic [3:0]    src_pin;
    logic [15:0]   src_balance, dst_balance;

    logic          wa_en, wb_en;
    logic [IW-1:0] wa_idx, wb_idx;
    logic [3:0]    wa_pin;
    logic [15:0]   wa_balance, wb_balance;

    logic          valid_code, accept, auth_ok;
    logic [16:0]   dep_sum, dst_sum;

    atm_account_table #(.N(NUM_ACCOUNTS), .IW(IW)) u_table (
        .clk_i         (clk),
        .rst_i         (rst),
        .src_number_i  (accNumber),
        .dst_number_i  (destinationAcc),
        .src_hit_o     (src_hit),
        .src_idx_o     (src_idx),
        .src_pin_o     (src_pin),
        .src_balance_o (src_balance),
        .dst_hit_o     (dst_hit),
        .dst_idx_o     (dst_idx),
        .dst_balance_o (dst_balance),
        .wa_en_i       (wa_en),
        .wa_idx_i      (wa_idx),
        .wa_pin_i      (wa_pin),
        .wa_balance_i  (wa_balance),
        .wb_en_i       (wb_en),
        .wb_idx_i      (wb_idx),
        .wb_balance_i  (wb_balance)
    );

    // Edge-style acceptance: a held action runs once; re-issuing it needs a different code in between.
    assign valid_code = (action == ACT_INQUIRY) || action[2];
    assign accept     = valid_code && (action != prev_action_q);
    assign auth_ok    = src_hit && (pin == src_pin);

    // 17-bit sums expose overflow in the carry bit.
    assign dep_sum = {1'b0, src_balance} + {1'b0, amount};
    assign dst_sum = {1'b0, dst_balance} + {1'b0, amount};

    always_comb begin
        balance_d  = balance_q;
        success_d  = success_q;
        pin_ok_d   = pin_ok_q;
        wa_en      = 1'b0;
        wa_idx     = src_idx;
        wa_pin     = src_pin;
        wa_balance = src_balance;
        wb_en      = 1'b0;
        wb_idx     = dst_idx;
        wb_balance = dst_balance;
        if (accept) begin
            balance_d = '0;
            success_d = 1'b0;
            pin_ok_d  = 1'b0;
            if (auth_ok) begin
                balance_d = src_balance;
                case (action)
                    ACT_INQUIRY: success_d = 1'b1;
                    ACT_WITHDRAW: begin
                        if (amount <= src_balance) begin
                            wa_en      = 1'b1;
                            wa_balance = src_balance - amount;
                            balance_d  = src_balance - amount;
                            success_d  = 1'b1;
                        end
                    end
                    ACT_DEPOSIT: begin
                        if (!dep_sum[16]) begin
                            wa_en      = 1'b1;
                            wa_balance = dep_sum[15:0];
                            balance_d  = dep_sum[15:0];
                            success_d  = 1'b1;
                        end
                    end
                    ACT_TRANSFER: begin
                        // Distinct indices guarantee the two write ports never target one entry.
                        if (dst_hit && (dst_idx != src_idx) && (amount <= src_balance) && !dst_sum[16]) begin
                            wa_en      = 1'b1;
                            wa_balance = src_balance - amount;
                            wb_en      = 1'b1;
                            wb_balance = dst_sum[15:0];
                            balance_d  = src_balance - amount;
                            success_d  = 1'b1;
                        end
                    end
                    ACT_PIN_CHANGE: begin
                        if (pinChange) begin
                            wa_en     = 1'b1;
                            wa_pin    = newPin;
                            success_d = 1'b1;
                            pin_ok_d  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_action_q <= ACT_IDLE;
            balance_q     <= '0;
            success_q     <= 1'b0;
            pin_ok_q      <= 1'b0;
        end else begin
            prev_action_q <= action;
            balance_q     <= balance_d;
            success_q     <= success_d;
            pin_ok_q      <= pin_ok_d;
        end
    end

    assign balance            = balance_q;
    assign transactionSuccess = success_q;
    assign pinSuccess         = pin_ok_q;

endmodule

// File: tb/tb_atm.sv
// tb/tb_atm.sv - directed self-checking bench for the atm engine
module tb_atm;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] accNumber;
    logic [3:0]  pin;
    logic [2:0]  action;
    logic [15:0] amount;
    logic        pinChange;
    logic [3:0]  newPin;
    logic [11:0] destinationAcc;
    logic [15:0] balance;
    logic        transactionSuccess;
    logic        pinSuccess;

    int errors = 0;
    int checks = 0;

    atm dut (
        .clk                (clk),
        .rst                (rst),
        .accNumber          (accNumber),
        .pin                (pin),
        .action             (action),
        .amount             (amount),
        .pinChange          (pinChange),
        .newPin             (newPin),
        .destinationAcc     (destinationAcc),
        .balance            (balance),
        .transactionSuccess (transactionSuccess),
        .pinSuccess         (pinSuccess)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect3(input string tag, input logic [15:0] bal, input logic s, input logic p);
        chk({tag, ".balance"}, balance, bal);
        chk({tag, ".success"}, {15'd0, transactionSuccess}, {15'd0, s});
        chk({tag, ".pinSuccess"}, {15'd0, pinSuccess}, {15'd0, p});
    endtask

    // Apply one command and advance past the edge that samples it.
    task automatic cmd(input logic [11:0] acc, input logic [3:0] p, input logic [2:0] act,
                       input logic [15:0] amt, input logic pc, input logic [3:0] np,
                       input logic [11:0] dst);
        accNumber      = acc;
        pin            = p;
        action         = act;
        amount         = amt;
        pinChange      = pc;
        newPin         = np;
        destinationAcc = dst;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cmd(12'h000, 4'd0, 3'b000, 16'd0, 1'b0, 4'd0, 12'h000);
    endtask

    initial begin
        rst = 1'b1;
        accNumber = '0; pin = '0; action = '0; amount = '0;
        pinChange = 1'b0; newPin = '0; destinationAcc = '0;
        @(posedge clk); @(posedge clk); #1;
        expect3("reset", 16'd0, 1'b0, 1'b0);
        rst = 1'b0;

        cmd(12'h0A1, 4'd1, 3'b011, 16'd0, 1'b0, 4'd0, 12'h000);
        expect3("inq_a1", 16'd1000, 1'b1, 1'b0);
        cmd(12'h0A1, 4'd1, 3'b011, 16'd0, 1'b0, 4'd0, 12'h000);
        expect3("inq_hold", 16'd1000, 1'b1, 1'b0);

        cmd(12'h0A1, 4'd1, 3'b101, 16'd500, 1'b0, 4'd0, 12'h000);
        expect3("dep500", 16'd1500, 1'b1, 1'b0);
        cmd(12'h0A1, 4'd1, 3'b101, 16'd500, 1'b0, 4'd0, 12'h000);
        chk("dep_hold_once", balance, 16'd1500);

        cmd(12'h0A1, 4'd1, 3'b100, 16'd200, 1'b0, 4'd0, 12'h000);
        expect3("wd200", 16'd1300, 1'b1, 1'b0);
        cmd(12'h0A1, 4'd1, 3'b110, 16'd300, 1'b0, 4'd0, 12'h0B2);
        expect3("xfer300", 16'd1000, 1'b1, 1'b0);
        cmd(12'h0B2, 4'd2, 3'b011, 16'd0, 1'b0, 4'd0, 12'h000);
        expect3("inq_b2", 16'd800, 1'b1, 1'b0);

        idle();
        chk("idle_hold", balance, 16'd800);
        cmd(12'h0A1, 4'd1, 3'b001, 16'd0, 1'b0, 4'd0, 12'h000);
        expect3("noop001_hold", 16'd800, 1'b1, 1'b0);

        cmd(12'h0A1, 4'd1, 3'b111, 16'd0, 1'b1, 4'd9, 12'h000);
        expect3("pinchg", 16'd1000, 1'b1, 1'b1);
        cmd(12'h0A1, 4'd1, 3'b011, 16'd0, 1'b0, 4'd0, 12'h000);
        expect3("inq_oldpin", 16'd0, 1'b0, 1'b0);
        idle();
        cmd(12'h0A1, 4'd9, 3'b011, 16'd0, 1'b0, 4'd0, 12'h000);
        expect3("inq_newpin", 16'd1000, 1'b1, 1'b0);

        cmd(12'h0A1, 4'd9, 3'b100, 16'd2000, 1'b0, 4'd0, 12'h000);
        expect3("wd_over", 16'd1000, 1'b0, 1'b0);
        cmd(12'h0A1, 4'd9, 3'b110, 16'd10, 1'b0, 4'd0, 12'h123);
        expect3("xfer_unknown", 16'd1000, 1'b0, 1'b0);
        idle();
        cmd(12'h0A1, 4'd9, 3'b110, 16'd10, 1'b0, 4'd0, 12'h0A1);
        expect3("xfer_self", 16'd1000, 1'b0, 1'b0);
        cmd(12'h0A1, 4'd9, 3'b101, 16'd65000, 1'b0, 4'd0, 12'h000);
        expect3("dep_ovf", 16'd1000, 1'b0, 1'b0);
        cmd(12'h0A1, 4'd9, 3'b111, 16'd0, 1'b0, 4'd5, 12'h000);
        expect3("pinchg_noen", 16'd1000, 1'b0, 1'b0);
        cmd(12'h0A1, 4'd9, 3'b011, 16'd0, 1'b0, 4'd0, 12'h000);
        expect3("inq_after_fails", 16'd1000, 1'b1, 1'b0);
        idle();
        cmd(12'h0B2, 4'd2, 3'b011, 16'd0, 1'b0, 4'd0, 12'h000);
        expect3("inq_b2_unchanged", 16'd800, 1'b1, 1'b0);

        cmd(12'h0A1, 4'd9, 3'b100, 16'd100, 1'b0, 4'd0, 12'h000);
        chk("wd100_first", balance, 16'd900);
        idle();
        cmd(12'h0A1, 4'd9, 3'b100, 16'd100, 1'b0, 4'd0, 12'h000);
        chk("wd100_second", balance, 16'd800);
        cmd(12'h0A1, 4'd9, 3'b100, 16'd100, 1'b0, 4'd0, 12'h000);
        chk("wd100_repeat_ignored", balance, 16'd800);
        idle();
        cmd(12'h0A1, 4'd9, 3'b011, 16'd0, 1'b0, 4'd0, 12'h000);
        expect3("inq_after_repeat", 16'd800, 1'b1, 1'b0);

        rst = 1'b1;
        cmd(12'h0A1, 4'd9, 3'b101, 16'd100, 1'b0, 4'd0, 12'h000);
        expect3("reset_during_dep", 16'd0, 1'b0, 1'b0);
        rst = 1'b0;
        cmd(12'h0A1, 4'd1, 3'b011, 16'd0, 1'b0, 4'd0, 12'h000);
        expect3("post_reset_a1", 16'd1000, 1'b1, 1'b0);
        idle();
        cmd(12'h0B2, 4'd2, 3'b011, 16'd0, 1'b0, 4'd0, 12'h000);
        expect3("post_reset_b2", 16'd500, 1'b1, 1'b0);
        idle();
        cmd(12'h0D4, 4'd4, 3'b011, 16'd0, 1'b0, 4'd0, 12'h000);
        expect3("post_reset_d4", 16'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
